// File: rtl/motor_mixer.sv
// X-frame motor mixer: mixes one flight command into four clamped motor speeds,
// then strobes each speed into its pwm channel in order 0..3 when not busy.
// Optional arming input enabled by defining MOTOR_MIXER_ARM_EN.
module motor_mixer #(
    parameter int MIN_SPEED = 256,
    parameter int MAX_SPEED = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef MOTOR_MIXER_ARM_EN
    input  logic        arm,
`endif
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] throttle,
    input  logic [15:0] roll,
    input  logic [15:0] pitch,
    input  logic [15:0] yaw,
    output logic [15:0] speed_0,
    output logic [15:0] speed_1,
    output logic [15:0] speed_2,
    output logic [15:0] speed_3,
    output logic [3:0]  speed_oe,
    input  logic [3:0]  pwm_busy,
    output logic [3:0]  sat_flags,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, MIX, DISPATCH, DONE} state_t;

    localparam logic signed [18:0] MIN_S  = 19'(MIN_SPEED);
    localparam logic signed [18:0] MAX_S  = 19'(MAX_SPEED);
    localparam logic [15:0]        MIN16  = 16'(MIN_SPEED);
    localparam logic [15:0]        MAX16  = 16'(MAX_SPEED);

    state_t      state;
    logic [1:0]  k;
    logic [15:0] t_q;
    logic [15:0] r_q;
    logic [15:0] p_q;
    logic [15:0] y_q;
    logic        mix_en;

    logic signed [18:0] t_ext;
    logic signed [18:0] r_ext;
    logic signed [18:0] p_ext;
    logic signed [18:0] y_ext;
    logic signed [18:0] sum;
    logic               neg_r;
    logic               neg_p;
    logic               neg_y;
    logic [15:0]        mixed;
    logic               mix_sat;

`ifdef MOTOR_MIXER_ARM_EN
    logic arm_q;
    assign mix_en = arm_q;
`else
    assign mix_en = 1'b1;
`endif

    // Sign pattern of the X-frame mix for motor k; one shared adder tree.
    assign neg_r = k[0] ^ k[1];
    assign neg_p = k[1];
    assign neg_y = ~k[0];

    assign t_ext = {3'b000, t_q};
    assign r_ext = {{3{r_q[15]}}, r_q};
    assign p_ext = {{3{p_q[15]}}, p_q};
    assign y_ext = {{3{y_q[15]}}, y_q};
    assign sum   = t_ext + (neg_r ? -r_ext : r_ext)
                         + (neg_p ? -p_ext : p_ext)
                         + (neg_y ? -y_ext : y_ext);

    always_comb begin
        mixed   = sum[15:0];
        mix_sat = 1'b0;
        if (!mix_en) begin
            mixed = MIN16;
        end else if (sum < MIN_S) begin
            mixed   = MIN16;
            mix_sat = 1'b1;
        end else if (sum > MAX_S) begin
            mixed   = MAX16;
            mix_sat = 1'b1;
        end
    end

    // Strobes and done are single-cycle pulses; everything else is held.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state     <= IDLE;
            k         <= 2'd0;
            cmd_ready <= 1'b1;
            t_q       <= 16'd0;
            r_q       <= 16'd0;
            p_q       <= 16'd0;
            y_q       <= 16'd0;
`ifdef MOTOR_MIXER_ARM_EN
            arm_q     <= 1'b0;
`endif
            speed_0   <= MIN16;
            speed_1   <= MIN16;
            speed_2   <= MIN16;
            speed_3   <= MIN16;
            speed_oe  <= 4'b0000;
            sat_flags <= 4'b0000;
            done      <= 1'b0;
        end else begin
            speed_oe <= 4'b0000;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        t_q       <= throttle;
                        r_q       <= roll;
                        p_q       <= pitch;
                        y_q       <= yaw;
`ifdef MOTOR_MIXER_ARM_EN
                        arm_q     <= arm;
`endif
                        k         <= 2'd0;
                        cmd_ready <= 1'b0;
                        state     <= MIX;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                MIX: begin
                    case (k)
                        2'd0: speed_0 <= mixed;
                        2'd1: speed_1 <= mixed;
                        2'd2: speed_2 <= mixed;
                        2'd3: speed_3 <= mixed;
                    endcase
                    sat_flags[k] <= mix_sat;
                    if (k == 2'd3) begin
                        k     <= 2'd0;
                        state <= DISPATCH;
                    end else begin
                        k <= k + 2'd1;
                    end
                end
                DISPATCH: begin
                    // A busy channel stalls the sequence so order 0..3 is kept.
                    if (!pwm_busy[k]) begin
                        speed_oe <= 4'b0001 << k;
                        if (k == 2'd3) begin
                            k     <= 2'd0;
                            state <= DONE;
                        end else begin
                            k <= k + 2'd1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_motor_mixer.sv
// Self-checking bench for motor_mixer: behavioural model compared every cycle,
// directed literal checks, then randomized commands and busy patterns.
module tb_motor_mixer;

    localparam int MIN_SPEED = 256;
    localparam int MAX_SPEED = 65535;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] throttle = '0;
    logic [15:0] roll = '0;
    logic [15:0] pitch = '0;
    logic [15:0] yaw = '0;
    logic [15:0] speed_0;
    logic [15:0] speed_1;
    logic [15:0] speed_2;
    logic [15:0] speed_3;
    logic [3:0]  speed_oe;
    logic [3:0]  pwm_busy = '0;
    logic [3:0]  sat_flags;
    logic        done;
`ifdef MOTOR_MIXER_ARM_EN
    logic        arm = 1'b1;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int oe_rel[4];
    int oe_count[4];
    int done_count = 0;
    int done_rel = 0;

    // Behavioural model state
    int       m_phase;
    int       m_idx;
    int       m_val[4];
    bit       m_sat[4];
    bit       m_armed;
    int       exp_speed[4];
    logic [3:0] exp_oe;
    logic [3:0] exp_sat;
    logic     exp_done;
    logic     exp_ready;

    motor_mixer #(.MIN_SPEED(MIN_SPEED), .MAX_SPEED(MAX_SPEED)) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef MOTOR_MIXER_ARM_EN
        .arm(arm),
`endif
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .throttle(throttle),
        .roll(roll),
        .pitch(pitch),
        .yaw(yaw),
        .speed_0(speed_0),
        .speed_1(speed_1),
        .speed_2(speed_2),
        .speed_3(speed_3),
        .speed_oe(speed_oe),
        .pwm_busy(pwm_busy),
        .sat_flags(sat_flags),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic int mix_speed(input int ch, input int t, input int r, input int p,
                                     input int y, input bit armed, output bit sat);
        int s;
        case (ch)
            0:       s = t + r + p - y;
            1:       s = t - r + p + y;
            2:       s = t - r - p - y;
            default: s = t + r - p + y;
        endcase
        sat = 1'b0;
        if (!armed) return MIN_SPEED;
        if (s < MIN_SPEED) begin
            sat = 1'b1;
            return MIN_SPEED;
        end
        if (s > MAX_SPEED) begin
            sat = 1'b1;
            return MAX_SPEED;
        end
        return s;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference model: a command is mixed one motor per cycle, then channels
    // are released in order as each one's busy flag is seen low.
    initial forever begin
        @(posedge clk or posedge rst_n);
        if (rst_n) begin
            m_phase   = 0;
            m_idx     = 0;
            for (int i = 0; i < 4; i++) exp_speed[i] = MIN_SPEED;
            exp_oe    = 4'b0;
            exp_sat   = 4'b0;
            exp_done  = 1'b0;
            exp_ready = 1'b1;
        end else begin
            exp_oe   = 4'b0;
            exp_done = 1'b0;
            case (m_phase)
                0: begin
                    if (exp_ready && cmd_valid) begin
`ifdef MOTOR_MIXER_ARM_EN
                        m_armed = arm;
`else
                        m_armed = 1'b1;
`endif
                        for (int i = 0; i < 4; i++)
                            m_val[i] = mix_speed(i, int'(throttle), int'($signed(roll)),
                                                 int'($signed(pitch)), int'($signed(yaw)),
                                                 m_armed, m_sat[i]);
                        m_idx     = 0;
                        exp_ready = 1'b0;
                        m_phase   = 1;
                    end else begin
                        exp_ready = 1'b1;
                    end
                end
                1: begin
                    exp_speed[m_idx] = m_val[m_idx];
                    exp_sat[m_idx]   = m_sat[m_idx];
                    m_idx++;
                    if (m_idx == 4) begin
                        m_idx   = 0;
                        m_phase = 2;
                    end
                end
                2: begin
                    if (!pwm_busy[m_idx]) begin
                        exp_oe[m_idx] = 1'b1;
                        m_idx++;
                        if (m_idx == 4) m_phase = 3;
                    end
                end
                default: begin
                    exp_done = 1'b1;
                    m_phase  = 0;
                end
            endcase
        end
    end

    initial forever begin
        @(negedge clk);
        check_output("speed_0", 32'(speed_0), 32'(exp_speed[0]));
        check_output("speed_1", 32'(speed_1), 32'(exp_speed[1]));
        check_output("speed_2", 32'(speed_2), 32'(exp_speed[2]));
        check_output("speed_3", 32'(speed_3), 32'(exp_speed[3]));
        check_output("speed_oe", 32'(speed_oe), 32'(exp_oe));
        check_output("sat_flags", 32'(sat_flags), 32'(exp_sat));
        check_output("done", 32'(done), 32'(exp_done));
        check_output("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
    end

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (speed_oe[i] === 1'b1) begin
                oe_rel[i] = cyc - accept_cyc;
                oe_count[i]++;
            end
        end
        if (done === 1'b1) done_count++;
    end

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) begin
            oe_count[i] = 0;
            oe_rel[i]   = -1;
        end
        done_count = 0;
    endtask

    task automatic apply_stimulus(input logic [15:0] t, input logic [15:0] r,
                                  input logic [15:0] p, input logic [15:0] y);
        int waited = 0;
        while (cmd_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (cmd_ready !== 1'b1) check_output("ready_timeout", 32'(cmd_ready), 32'd1);
        clear_counts();
        throttle  = t;
        roll      = r;
        pitch     = p;
        yaw       = y;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) check_output("done_timeout", 32'(done), 32'd1);
        done_rel = cyc - accept_cyc;
        @(negedge clk);
    endtask

    task automatic check_strobes_once();
        for (int i = 0; i < 4; i++) check_output("oe_count", 32'(oe_count[i]), 32'd1);
        check_output("done_count", 32'(done_count), 32'd1);
    endtask

    initial begin
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_output("rst_speed_0", 32'(speed_0), 32'd256);
        check_output("rst_speed_3", 32'(speed_3), 32'd256);
        check_output("rst_oe", 32'(speed_oe), 32'd0);
        check_output("rst_ready", 32'(cmd_ready), 32'd1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        // Nominal latency
        apply_stimulus(16'd20000, 16'd0, 16'd0, 16'd0);
        wait_done(40);
        for (int i = 0; i < 4; i++) check_output("oe_cycle", 32'(oe_rel[i] + 1), 32'(6 + i));
        check_output("done_cycle", 32'(done_rel + 1), 32'd10);
        check_output("nom_speed_0", 32'(speed_0), 32'd20000);
        check_output("nom_speed_3", 32'(speed_3), 32'd20000);
        check_output("nom_sat", 32'(sat_flags), 32'd0);
        check_strobes_once();

        // Mixed corrections
        apply_stimulus(16'd30000, 16'd1000, 16'hFE0C, 16'd200);
        wait_done(40);
        check_output("mix_speed_0", 32'(speed_0), 32'd30300);
        check_output("mix_speed_1", 32'(speed_1), 32'd28700);
        check_output("mix_speed_2", 32'(speed_2), 32'd29300);
        check_output("mix_speed_3", 32'(speed_3), 32'd31700);
        check_output("model_speed_1", 32'(exp_speed[1]), 32'd28700);

        // Upper and lower clamps
        apply_stimulus(16'd65000, 16'd1000, 16'd1000, 16'd0);
        wait_done(40);
        check_output("hi_speed_0", 32'(speed_0), 32'd65535);
        check_output("hi_speed_2", 32'(speed_2), 32'd63000);
        check_output("hi_sat", 32'(sat_flags), 32'b0001);
        apply_stimulus(16'd100, 16'hFFCE, 16'hFFCE, 16'hFFCE);
        wait_done(40);
        check_output("lo_speed_2", 32'(speed_2), 32'd256);
        check_output("lo_sat", 32'(sat_flags), 32'b1111);

        // Busy channel 1 held while garbage commands are offered
        pwm_busy = 4'b0010;
        apply_stimulus(16'd40000, 16'd0, 16'd0, 16'd0);
        begin
            int n = 0;
            while (oe_count[0] == 0 && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check_output("busy_oe0", 32'(oe_count[0]), 32'd1);
        for (int i = 0; i < 20; i++) begin
            cmd_valid = 1'b1;
            throttle  = 16'($urandom);
            roll      = 16'($urandom);
            @(negedge clk);
        end
        check_output("busy_oe1_held", 32'(oe_count[1]), 32'd0);
        cmd_valid = 1'b0;
        pwm_busy  = 4'b0000;
        wait_done(40);
        check_output("busy_oe1_late", 32'(oe_rel[1] >= 25), 32'd1);
        check_output("busy_oe2", 32'(oe_rel[2]), 32'(oe_rel[1] + 1));
        check_output("busy_oe3", 32'(oe_rel[3]), 32'(oe_rel[1] + 2));
        check_output("busy_done", 32'(done_rel), 32'(oe_rel[3] + 1));
        check_output("busy_speed_0", 32'(speed_0), 32'd40000);
        check_strobes_once();

        // Reset in the middle of mixing
        apply_stimulus(16'd50000, 16'd100, 16'd100, 16'd100);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check_output("arst_speed_0", 32'(speed_0), 32'd256);
        check_output("arst_oe", 32'(speed_oe), 32'd0);
        check_output("arst_sat", 32'(sat_flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        clear_counts();
        repeat (12) @(negedge clk);
        check_output("arst_no_oe", 32'(oe_count[0] + oe_count[1] + oe_count[2] + oe_count[3]), 32'd0);
        check_output("arst_no_done", 32'(done_count), 32'd0);
        apply_stimulus(16'd20000, 16'd0, 16'd0, 16'd0);
        wait_done(40);
        check_output("arst_next_speed", 32'(speed_1), 32'd20000);
        check_strobes_once();

`ifdef MOTOR_MIXER_ARM_EN
        arm = 1'b0;
        apply_stimulus(16'd40000, 16'd0, 16'd0, 16'd0);
        wait_done(40);
        check_output("disarm_speed_0", 32'(speed_0), 32'd256);
        check_output("disarm_speed_3", 32'(speed_3), 32'd256);
        check_output("disarm_sat", 32'(sat_flags), 32'd0);
        check_strobes_once();
        arm = 1'b1;
`endif

        // Randomized commands, busy patterns and command offers
        for (int i = 0; i < 2000; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            throttle  = 16'($urandom);
            roll      = 16'($urandom);
            pitch     = 16'($urandom);
            yaw       = 16'($urandom);
            for (int b = 0; b < 4; b++) pwm_busy[b] = ($urandom_range(0, 9) < 3);
`ifdef MOTOR_MIXER_ARM_EN
            arm = ($urandom_range(0, 3) != 0);
`endif
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        pwm_busy  = 4'b0000;
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
